// File: rtl/tdc_pkg.sv
// Shared widths, FSM state encoding and the stored hit record for the TDC front end.
package tdc_pkg;

    localparam int unsigned COARSE_W = 10;
    localparam int unsigned FINE_W   = 5;
    localparam int unsigned MAX_HITS = 3;
    localparam int unsigned INT_W    = 5;
    localparam int unsigned CNT_W    = 2;
    localparam int unsigned DATA_W   = COARSE_W + FINE_W;

    localparam logic [COARSE_W-1:0] CoarseMax = '1;
    localparam logic [CNT_W-1:0]    HitsFull  = CNT_W'(MAX_HITS);
    localparam logic [CNT_W-1:0]    CntOne    = CNT_W'(1);

    typedef enum logic [1:0] {
        StIdle,
        StArmed,
        StDone
    } tdc_state_e;

    typedef struct packed {
        logic [COARSE_W-1:0] coarse;
        logic [FINE_W-1:0]   fine;
        logic [INT_W-1:0]    intensity;
    } hit_t;

    // Number of SPADs that fired; 16 needs the full 5-bit result.
    function automatic logic [INT_W-1:0] popcount16(input logic [15:0] v);
        logic [INT_W-1:0] sum;
        sum = '0;
        for (int i = 0; i < 16; i++) begin
            sum = sum + INT_W'(v[i]);
        end
        return sum;
    endfunction

endpackage

// File: rtl/tdc_phase_enc.sv
// Thermometer-to-binary fine phase encoder: returns the lowest tap index that sits on a
// 0->1 boundary of the rotating DLL pattern; all-0 and all-1 patterns encode as 0.
module tdc_phase_enc
    import tdc_pkg::*;
(
    input  logic [31:0]       phase_i,
    output logic [FINE_W-1:0] fine_o
);

    logic [4:0] prev_idx;

    always_comb begin
        fine_o   = '0;
        prev_idx = '0;
        // Scan downwards so the lowest matching index is the one that sticks.
        for (int i = 31; i >= 0; i--) begin
            prev_idx = 5'(i) - 5'd1;
            if (phase_i[5'(i)] && !phase_i[prev_idx]) begin
                fine_o = FINE_W'(i);
            end
        end
    end

endmodule

// File: rtl/tdc_top_block.sv
// Multi-hit TDC front end: captures up to MAX_HITS {coarse, fine, intensity} hits after a
// start edge and streams them out. Build option TDC_TGATE_EN qualifies hits with TDC_tgate.
module tdc_top_block
    import tdc_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic [31:0]       DLL_Phase,
    input  logic              clk5,
    input  logic              TDC_start,
    input  logic              TDC_trigger,
    input  logic [15:0]       TDC_spaden,
    input  logic              TDC_tgate,
    output logic [DATA_W-1:0] TDC_Odata,
    output logic [INT_W-1:0]  TDC_Oint,
    output logic [CNT_W-1:0]  TDC_Onum,
    output logic              TDC_Olast,
    output logic              TDC_Ovalid,
    input  logic              TDC_Oready,
    output logic              TDC_INT
);

    logic start_q, start_prev_q, trig_q, trig_prev_q, clk5_q, clk5_prev_q;
    logic start_rise, trig_rise, clk5_rise, gate_ok;

    tdc_state_e          state_q, state_d;
    logic [COARSE_W-1:0] coarse_q, coarse_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    rd_q, rd_d;
    hit_t                hits_q [MAX_HITS];
    hit_t                hits_d [MAX_HITS];
    hit_t                new_hit;
    logic [FINE_W-1:0]   fine;

    logic [DATA_W-1:0]   odata_q, odata_d;
    logic [INT_W-1:0]    oint_q, oint_d;
    logic [CNT_W-1:0]    onum_q, onum_d;
    logic                olast_q, olast_d;
    logic                ovalid_q, ovalid_d;
    logic                int_q, int_d;

    tdc_phase_enc u_phase_enc (
        .phase_i (DLL_Phase),
        .fine_o  (fine)
    );

    assign start_rise = start_q && !start_prev_q;
    assign trig_rise  = trig_q && !trig_prev_q;
    assign clk5_rise  = clk5_q && !clk5_prev_q;

`ifdef TDC_TGATE_EN
    assign gate_ok = TDC_tgate;
`else
    logic unused_tgate;
    assign unused_tgate = TDC_tgate;
    assign gate_ok      = 1'b1;
`endif

    assign new_hit = '{coarse: coarse_q, fine: fine, intensity: popcount16(TDC_spaden)};

    always_comb begin
        state_d  = state_q;
        coarse_d = coarse_q;
        cnt_d    = cnt_q;
        rd_d     = rd_q;
        hits_d   = hits_q;
        odata_d  = odata_q;
        oint_d   = oint_q;
        onum_d   = onum_q;
        olast_d  = olast_q;
        ovalid_d = ovalid_q;
        int_d    = int_q;

        unique case (state_q)
            StIdle: begin
                if (start_rise) begin
                    state_d  = StArmed;
                    coarse_d = '0;
                    cnt_d    = '0;
                    hits_d   = '{default: '0};
                end
            end
            StArmed: begin
                if (start_rise) begin
                    coarse_d = '0;
                    cnt_d    = '0;
                    hits_d   = '{default: '0};
                end else begin
                    // The hit records coarse_q, i.e. the value before any same-cycle increment.
                    if (trig_rise && gate_ok && (cnt_q < HitsFull)) begin
                        hits_d[cnt_q] = new_hit;
                        cnt_d         = cnt_q + CntOne;
                    end
                    if (clk5_rise && (coarse_q != CoarseMax)) begin
                        coarse_d = coarse_q + COARSE_W'(1);
                    end
                    if ((cnt_d == HitsFull) || (coarse_d == CoarseMax)) begin
                        state_d = StDone;
                        int_d   = 1'b1;
                        rd_d    = '0;
                        if (cnt_d != '0) begin
                            ovalid_d = 1'b1;
                            odata_d  = {hits_d[0].coarse, hits_d[0].fine};
                            oint_d   = hits_d[0].intensity;
                            onum_d   = cnt_d;
                            olast_d  = (cnt_d == CntOne);
                        end
                    end
                end
            end
            StDone: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                    int_d   = 1'b0;
                end else if (ovalid_q && TDC_Oready) begin
                    if (olast_q) begin
                        state_d  = StIdle;
                        int_d    = 1'b0;
                        ovalid_d = 1'b0;
                        odata_d  = '0;
                        oint_d   = '0;
                        onum_d   = '0;
                        olast_d  = 1'b0;
                    end else begin
                        rd_d    = rd_q + CntOne;
                        odata_d = {hits_q[rd_d].coarse, hits_q[rd_d].fine};
                        oint_d  = hits_q[rd_d].intensity;
                        olast_d = (rd_d == (cnt_q - CntOne));
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            start_q      <= 1'b0;
            start_prev_q <= 1'b0;
            trig_q       <= 1'b0;
            trig_prev_q  <= 1'b0;
            clk5_q       <= 1'b0;
            clk5_prev_q  <= 1'b0;
            state_q      <= StIdle;
            coarse_q     <= '0;
            cnt_q        <= '0;
            rd_q         <= '0;
            hits_q       <= '{default: '0};
            odata_q      <= '0;
            oint_q       <= '0;
            onum_q       <= '0;
            olast_q      <= 1'b0;
            ovalid_q     <= 1'b0;
            int_q        <= 1'b0;
        end else begin
            start_q      <= TDC_start;
            start_prev_q <= start_q;
            trig_q       <= TDC_trigger;
            trig_prev_q  <= trig_q;
            clk5_q       <= clk5;
            clk5_prev_q  <= clk5_q;
            state_q      <= state_d;
            coarse_q     <= coarse_d;
            cnt_q        <= cnt_d;
            rd_q         <= rd_d;
            hits_q       <= hits_d;
            odata_q      <= odata_d;
            oint_q       <= oint_d;
            onum_q       <= onum_d;
            olast_q      <= olast_d;
            ovalid_q     <= ovalid_d;
            int_q        <= int_d;
        end
    end

    assign TDC_Odata  = odata_q;
    assign TDC_Oint   = oint_q;
    assign TDC_Onum   = onum_q;
    assign TDC_Olast  = olast_q;
    assign TDC_Ovalid = ovalid_q;
    assign TDC_INT    = int_q;

endmodule

// File: tb/tb_tdc_top_block.sv
// Bench for tdc_top_block: directed scenarios plus randomized windows, all checked each cycle
// against a transaction-level model of the measurement window.
module tb_tdc_top_block;

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic [31:0] DLL_Phase;
    logic        clk5 = 1'b0;
    logic        TDC_start, TDC_trigger, TDC_tgate, TDC_Oready;
    logic [15:0] TDC_spaden;
    logic [14:0] TDC_Odata;
    logic [4:0]  TDC_Oint;
    logic [1:0]  TDC_Onum;
    logic        TDC_Olast, TDC_Ovalid, TDC_INT;

    tdc_top_block dut (
        .clk_i       (clk_i),
        .rst_n       (rst_n),
        .DLL_Phase   (DLL_Phase),
        .clk5        (clk5),
        .TDC_start   (TDC_start),
        .TDC_trigger (TDC_trigger),
        .TDC_spaden  (TDC_spaden),
        .TDC_tgate   (TDC_tgate),
        .TDC_Odata   (TDC_Odata),
        .TDC_Oint    (TDC_Oint),
        .TDC_Onum    (TDC_Onum),
        .TDC_Olast   (TDC_Olast),
        .TDC_Ovalid  (TDC_Ovalid),
        .TDC_Oready  (TDC_Oready),
        .TDC_INT     (TDC_INT)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;
    int ready_mode = 1;  // 0: low, 1: high, 2: random

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name, input int budget);
        n_checks++;
        n_errors++;
        $display("FAIL %s: no response within %0d cycles at %0t", name, budget, $time);
    endtask

    // Free-running clk5 (period of four logic clocks) and the Oready driver.
    int c5_cnt = 0;
    always @(posedge clk_i) begin
        #2;
        c5_cnt++;
        if (c5_cnt == 2) begin
            clk5   = ~clk5;
            c5_cnt = 0;
        end
        case (ready_mode)
            0:       TDC_Oready = 1'b0;
            1:       TDC_Oready = 1'b1;
            default: TDC_Oready = 1'($urandom_range(0, 1));
        endcase
    end

    // ---------------- behavioural model ----------------
    typedef struct {
        int c;
        int f;
        int n;
    } mhit_t;

    function automatic int ref_fine(input logic [31:0] p);
        for (int i = 0; i < 32; i++) begin
            if (p[i] && !p[(i + 31) % 32]) return i;
        end
        return 0;
    endfunction

    mhit_t mhits[$];
    int    m_mode = 0;  // 0 idle, 1 measuring, 2 reporting
    int    m_coarse = 0;
    int    m_beat = 0;
    bit    exp_valid = 0, exp_int = 0;
    bit    s_start[2], s_trig[2], s_clk5[2];  // [0] newest sample

    always @(posedge clk_i or negedge rst_n) begin
        bit st_r, tr_r, c5_r, gate;
        if (!rst_n) begin
            m_mode = 0; m_coarse = 0; m_beat = 0; exp_valid = 0; exp_int = 0;
            mhits.delete();
            s_start = '{0, 0}; s_trig = '{0, 0}; s_clk5 = '{0, 0};
        end else begin
            st_r = s_start[0] && !s_start[1];
            tr_r = s_trig[0] && !s_trig[1];
            c5_r = s_clk5[0] && !s_clk5[1];
`ifdef TDC_TGATE_EN
            gate = TDC_tgate;
`else
            gate = 1'b1;
`endif
            case (m_mode)
                0: if (st_r) begin m_mode = 1; m_coarse = 0; mhits.delete(); end
                1: begin
                    if (st_r) begin
                        m_coarse = 0;
                        mhits.delete();
                    end else begin
                        if (tr_r && gate && mhits.size() < 3)
                            mhits.push_back('{m_coarse, ref_fine(DLL_Phase),
                                              $countones(TDC_spaden)});
                        if (c5_r && m_coarse < 1023) m_coarse++;
                        if (mhits.size() == 3 || m_coarse == 1023) begin
                            m_mode = 2; m_beat = 0; exp_int = 1;
                            exp_valid = (mhits.size() > 0);
                        end
                    end
                end
                default: begin
                    if (mhits.size() == 0) begin
                        m_mode = 0; exp_int = 0;
                    end else if (TDC_Oready) begin
                        m_beat++;
                        if (m_beat == mhits.size()) begin
                            m_mode = 0; exp_int = 0; exp_valid = 0;
                        end
                    end
                end
            endcase
            s_start[1] = s_start[0]; s_start[0] = TDC_start;
            s_trig[1]  = s_trig[0];  s_trig[0]  = TDC_trigger;
            s_clk5[1]  = s_clk5[0];  s_clk5[0]  = clk5;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk_i) begin
        check("ovalid", int'(TDC_Ovalid), int'(exp_valid));
        check("int", int'(TDC_INT), int'(exp_int));
        if (exp_valid && m_beat < mhits.size()) begin
            check("odata", int'(TDC_Odata), mhits[m_beat].c * 32 + mhits[m_beat].f);
            check("oint", int'(TDC_Oint), mhits[m_beat].n);
            check("onum", int'(TDC_Onum), mhits.size());
            check("olast", int'(TDC_Olast), int'(m_beat == mhits.size() - 1));
        end
    end

    // Transfer capture for the hand-computed checks.
    int cap_data[$], cap_int[$], cap_last[$], cap_num[$];
    int int_cnt = 0, valid_cnt = 0;
    always @(negedge clk_i) begin
        if (TDC_INT) int_cnt++;
        if (TDC_Ovalid) valid_cnt++;
        if (TDC_Ovalid && TDC_Oready) begin
            cap_data.push_back(int'(TDC_Odata));
            cap_int.push_back(int'(TDC_Oint));
            cap_last.push_back(int'(TDC_Olast));
            cap_num.push_back(int'(TDC_Onum));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #2;
        end
    endtask

    task automatic clear_caps();
        cap_data.delete(); cap_int.delete(); cap_last.delete(); cap_num.delete();
        int_cnt = 0; valid_cnt = 0;
    endtask

    task automatic pulse_start();
        TDC_start = 1'b1; cyc(2); TDC_start = 1'b0; cyc(1);
    endtask

    task automatic do_hit(input logic [15:0] sp, input logic [31:0] dll, input logic tg);
        TDC_spaden = sp; DLL_Phase = dll; TDC_tgate = tg; TDC_trigger = 1'b1;
        cyc(3);
        TDC_trigger = 1'b0;
        cyc(2);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (!(m_mode == 0 && !TDC_Ovalid && !TDC_INT) && n < budget) begin
            cyc(1);
            n++;
        end
        if (n >= budget) timeout(name, budget);
    endtask

    task automatic wait_valid(input int budget, input string name);
        int n = 0;
        while (!TDC_Ovalid && n < budget) begin
            cyc(1);
            n++;
        end
        if (n >= budget) timeout(name, budget);
    endtask

    task automatic three_hits(input int gap);
        do_hit(16'h0001, 32'h0000_00FF, 1'b1); cyc(gap);
        do_hit(16'h00F1, 32'h00FF_FF00, 1'b1); cyc(gap);
        do_hit(16'h0FF1, 32'hFF00_0000, 1'b1);
    endtask

    task automatic check_159(input string name);
        check({name, "_beats"}, cap_int.size(), 3);
        if (cap_int.size() == 3) begin
            check({name, "_oint0"}, cap_int[0], 1);
            check({name, "_oint1"}, cap_int[1], 5);
            check({name, "_oint2"}, cap_int[2], 9);
            check({name, "_onum"}, cap_num[2], 3);
        end
    endtask

    function automatic logic [31:0] rand_therm();
        logic [31:0] b;
        int k, r;
        k = $urandom_range(0, 32);
        r = $urandom_range(0, 31);
        b = (k == 32) ? 32'hFFFF_FFFF : 32'((64'd1 << k) - 64'd1);
        return (b << r) | (b >> (32 - r));
    endfunction

    // ---------------- scenarios ----------------
    initial begin
        rst_n = 1'b0;
        TDC_start = 0; TDC_trigger = 0; TDC_tgate = 1; TDC_spaden = '0; DLL_Phase = '0;
        TDC_Oready = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        check("rst_odata", int'(TDC_Odata), 0);
        check("rst_oint", int'(TDC_Oint), 0);
        check("rst_onum", int'(TDC_Onum), 0);
        check("rst_olast", int'(TDC_Olast), 0);
        check("rst_ovalid", int'(TDC_Ovalid), 0);
        check("rst_int", int'(TDC_INT), 0);
        // Model pins for the fine encoder.
        check("model_fine_hi", ref_fine(32'hFFFF_0000), 16);
        check("model_fine_lo", ref_fine(32'h0000_FFFF), 0);
        check("model_fine_all1", ref_fine(32'hFFFF_FFFF), 0);
        cyc(1);
        rst_n = 1'b1;
        cyc(3);

        // Three spaced hits, ready high.
        clear_caps(); ready_mode = 1;
        pulse_start();
        three_hits(12);
        wait_idle(200, "s1_idle");
        check_159("s1");
        check("s1_int_seen", int'(int_cnt > 0), 1);
        if (cap_data.size() == 3) begin
            check("s1_coarse_inc01", int'((cap_data[1] >> 5) > (cap_data[0] >> 5)), 1);
            check("s1_coarse_inc12", int'((cap_data[2] >> 5) > (cap_data[1] >> 5)), 1);
            check("s1_olast0", cap_last[0], 0);
            check("s1_olast1", cap_last[1], 0);
            check("s1_olast2", cap_last[2], 1);
        end

        // Backpressure: Oready low for 50 cycles.
        clear_caps(); ready_mode = 0;
        pulse_start();
        three_hits(8);
        wait_valid(100, "s2_valid");
        for (int i = 0; i < 50; i++) begin
            check("s2_hold_valid", int'(TDC_Ovalid), 1);
            check("s2_hold_oint", int'(TDC_Oint), 1);
            check("s2_hold_olast", int'(TDC_Olast), 0);
            check("s2_hold_int", int'(TDC_INT), 1);
            cyc(1);
        end
        ready_mode = 1;
        wait_idle(100, "s2_idle");
        check_159("s2");
        check("s2_int_after", int'(TDC_INT), 0);

        // Fourth and fifth triggers are ignored.
        clear_caps(); ready_mode = 0;
        pulse_start();
        three_hits(6);
        do_hit(16'h3FF1, 32'h0000_0FFF, 1'b1);
        do_hit(16'h30F1, 32'h000F_FFFF, 1'b1);
        check("s3_onum", int'(TDC_Onum), 3);
        ready_mode = 1;
        wait_idle(100, "s3_idle");
        check_159("s3");

        // No triggers: coarse saturates, single INT pulse, no beats.
        clear_caps();
        pulse_start();
        wait_idle(6000, "s4_sat");
        check("s4_int_cycles", int_cnt, 1);
        check("s4_valid_cycles", valid_cnt, 0);

        // Fine encoding at hit time.
        clear_caps();
        pulse_start();
        do_hit(16'h0001, 32'hFFFF_0000, 1'b1); cyc(4);
        do_hit(16'h0001, 32'h0000_FFFF, 1'b1); cyc(4);
        do_hit(16'h0001, 32'h0000_0000, 1'b1);
        wait_idle(100, "s5_idle");
        check("s5_beats", cap_data.size(), 3);
        if (cap_data.size() == 3) begin
            check("s5_fine0", cap_data[0] % 32, 16);
            check("s5_fine1", cap_data[1] % 32, 0);
            check("s5_fine2", cap_data[2] % 32, 0);
        end

        // Gated trigger first.
        clear_caps();
        pulse_start();
        do_hit(16'h0003, 32'h0000_00FF, 1'b0); cyc(4);
        three_hits(4);
        wait_idle(6000, "s6_idle");
        check("s6_beats", cap_int.size(), 3);
        if (cap_int.size() == 3) begin
`ifdef TDC_TGATE_EN
            check("s6_oint0", cap_int[0], 1);
            check("s6_oint2", cap_int[2], 9);
`else
            check("s6_oint0", cap_int[0], 2);
            check("s6_oint2", cap_int[2], 5);
`endif
        end

        // Reset after one hit aborts the window.
        clear_caps();
        pulse_start();
        do_hit(16'h00FF, 32'h0000_FFFF, 1'b1);
        rst_n = 1'b0; cyc(2); rst_n = 1'b1;
        cyc(60);
        check("s7_beats", cap_data.size(), 0);
        check("s7_int_cycles", int_cnt, 0);

        // Randomized windows with random backpressure, gating and restarts.
        ready_mode = 2;
        for (int w = 0; w < 25; w++) begin
            pulse_start();
            for (int a = 0; a < 60 && m_mode == 1; a++) begin
                if ($urandom_range(0, 11) == 0) pulse_start();
                else do_hit(16'($urandom), rand_therm(), 1'($urandom_range(0, 3) != 0));
                cyc($urandom_range(0, 6));
            end
            wait_idle(6000, "rand_idle");
        end

        cyc(5);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
